uart_cmd_parser: RTL

Byte-stream frame parser between the UART receiver and the display/control logic in the top level. It consumes received bytes with a one-cycle valid strobe, recognises framed commands (header, command, length, payload, checksum, tail), and checks length, checksum, tail and inter-byte timeout. Only complete, correct frames update its held outputs; those outputs drive the seven-segment data register and other control registers.

---
 rtl/uart_cmd_parser.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: framed command parser for the UART byte stream.
// Frame: HDR, CMD, LEN, LEN payload bytes, CHK, TAIL, with
// CHK = (CMD + LEN + sum of payload) mod 256. Only complete, correct frames
// update the held frame outputs; errors pulse err_pulse and record a code.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 500_000,
  parameter logic [7:0]  HDR         = 8'hA5,
  parameter logic [7:0]  TAIL        = 8'h5A
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 frame_valid,
  output logic [7:0]           frame_cmd,
  output logic [3:0]           frame_len,
  output logic [8*MAX_LEN-1:0] frame_payload,
  output logic                 err_pulse,
  output logic [2:0]           err_code,
  output logic [7:0]           frame_cnt,
  output logic [7:0]           err_cnt
);

  localparam int unsigned      GAP_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       LEN_MAX  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK,
    S_TAIL
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_CHK     = 3'd2,
    ERR_TAIL    = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_t;

  state_t                    state;
  logic [GAP_W-1:0]          gap;
  logic [7:0]                sh_cmd;
  logic [3:0]                sh_len;
  logic [MAX_LEN-1:0][7:0]   sh_buf;
  logic [7:0]                sum;
  logic [3:0]                idx;

  logic                      err_hit;
  err_t                      err_kind;

  // Classify the current cycle: byte-driven errors take priority over the
  // timeout, so a byte arriving in the firing cycle suppresses it.
  always_comb begin
    err_hit  = 1'b0;
    err_kind = ERR_NONE;
    if (rx_valid) begin
      case (state)
        S_LEN: begin
          if (rx_data > LEN_MAX) begin
            err_hit  = 1'b1;
            err_kind = ERR_LEN;
          end
        end
        S_CHK: begin
          if (rx_data != sum) begin
            err_hit  = 1'b1;
            err_kind = ERR_CHK;
          end
        end
        S_TAIL: begin
          if (rx_data != TAIL) begin
            err_hit  = 1'b1;
            err_kind = ERR_TAIL;
          end
        end
        default: ;
      endcase
    end else if (state != S_IDLE && gap == GAP_LAST) begin
      err_hit  = 1'b1;
      err_kind = ERR_TIMEOUT;
    end
  end

  // Frame FSM with shadow capture, gap timer, commit and error bookkeeping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      gap           <= '0;
      sh_cmd        <= '0;
      sh_len        <= '0;
      sh_buf        <= '0;
      sum           <= '0;
      idx           <= '0;
      frame_valid   <= 1'b0;
      frame_cmd     <= '0;
      frame_len     <= '0;
      frame_payload <= '0;
      err_pulse     <= 1'b0;
      err_code      <= '0;
      frame_cnt     <= '0;
      err_cnt       <= '0;
    end else begin
      frame_valid <= 1'b0;
      err_pulse   <= err_hit;
      if (err_hit) begin
        err_code <= err_kind;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end

      if (rx_valid) begin
        gap <= '0;
        case (state)
          S_IDLE: begin
            if (rx_data == HDR) begin
              state <= S_CMD;
            end
          end
          S_CMD: begin
            sh_cmd <= rx_data;
            sum    <= rx_data;
            state  <= S_LEN;
          end
          S_LEN: begin
            if (err_hit) begin
              state <= S_IDLE;
            end else begin
              sh_len <= rx_data[3:0];
              sum    <= sum + rx_data;
              idx    <= '0;
              state  <= (rx_data == 8'd0) ? S_CHK : S_DATA;
            end
          end
          S_DATA: begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) begin
                sh_buf[i] <= rx_data;
              end
            end
            sum <= sum + rx_data;
            idx <= idx + 4'd1;
            if (idx == sh_len - 4'd1) begin
              state <= S_CHK;
            end
          end
          S_CHK: begin
            state <= err_hit ? S_IDLE : S_TAIL;
          end
          S_TAIL: begin
            state <= S_IDLE;
            if (!err_hit) begin
              frame_cmd   <= sh_cmd;
              frame_len   <= sh_len;
              // Shadow bytes beyond LEN may be stale from an older frame.
              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                frame_payload[8*i +: 8] <= (4'(i) < sh_len) ? sh_buf[i] : 8'h00;
              end
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 8'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (err_hit) begin
          state <= S_IDLE;
          gap   <= '0;
        end else begin
          gap <= gap + 1'b1;
        end
      end
    end
  end

endmodule
